// File: rtl/ped_walk_scheduler.sv
// Pedestrian-crossing scheduler: latches crosswalk presses, requests an all-red hold
// from the traffic FSM, then runs a timed WALK and flashing DON'T WALK for the served set.
module ped_walk_scheduler #(
  parameter int unsigned WALK_TICKS  = 10,
  parameter int unsigned FLASH_TICKS = 6
) (
  input  logic       FPGA_CLK,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] ped_btn,
  input  logic       fsm_safe,
  output logic       walk_req,
  output logic [3:0] walk,
  output logic [3:0] dont_walk,
  output logic [3:0] pending,
  output logic       walk_done,
  output logic       abort,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WALK  = 3'd2,
    CLEAR = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [7:0] WALK_LOAD  = 8'(WALK_TICKS);
  localparam logic [7:0] FLASH_LOAD = 8'(FLASH_TICKS);

  state_t     state, state_n;
  logic [3:0] served, served_n;
  logic [3:0] hist;
  logic [3:0] pending_n;
  logic [7:0] cnt, cnt_n;
  logic       flash, flash_n;
  logic [3:0] walk_n, dont_walk_n;
  logic       walk_req_n, walk_done_n, abort_n;
  logic [3:0] press, press_ok;

  assign dbg_state = state;

  // Served crosswalks are non-zero only in WALK/CLEAR, so masking with them
  // drops repeat presses exactly while those crosswalks are being served.
  assign press    = ped_btn & ~hist;
  assign press_ok = press & ~served;

  always_comb begin
    state_n     = state;
    served_n    = served;
    pending_n   = pending | press_ok;
    cnt_n       = cnt;
    flash_n     = flash;
    walk_n      = walk;
    dont_walk_n = dont_walk;
    walk_req_n  = walk_req;
    walk_done_n = 1'b0;
    abort_n     = 1'b0;

    unique case (state)
      IDLE: begin
        walk_n      = 4'h0;
        dont_walk_n = 4'hF;
        walk_req_n  = 1'b0;
        if (pending != 4'h0) begin
          state_n    = REQ;
          walk_req_n = 1'b1;
        end
      end
      REQ: begin
        walk_req_n = 1'b1;
        if (fsm_safe) begin
          served_n    = pending;
          pending_n   = (pending | press_ok) & ~pending;
          cnt_n       = WALK_LOAD;
          walk_n      = pending;
          dont_walk_n = ~pending;
          state_n     = WALK;
        end
      end
      WALK, CLEAR: begin
        if (!fsm_safe) begin
          walk_n      = 4'h0;
          dont_walk_n = 4'hF;
          walk_req_n  = 1'b0;
          abort_n     = 1'b1;
          pending_n   = pending | press_ok | served;
          served_n    = 4'h0;
          state_n     = IDLE;
        end else if (tick) begin
          if (state == WALK) begin
            if (cnt == 8'd1) begin
              cnt_n       = FLASH_LOAD;
              flash_n     = 1'b1;
              walk_n      = 4'h0;
              dont_walk_n = 4'hF;
              state_n     = CLEAR;
            end else begin
              cnt_n = cnt - 8'd1;
            end
          end else begin
            flash_n = ~flash;
            if (cnt == 8'd1) begin
              walk_done_n = 1'b1;
              walk_req_n  = 1'b0;
              dont_walk_n = 4'hF;
              served_n    = 4'h0;
              state_n     = DONE;
            end else begin
              cnt_n       = cnt - 8'd1;
              dont_walk_n = ~served | ({4{~flash}} & served);
            end
          end
        end
      end
      DONE: begin
        walk_req_n = 1'b0;
        state_n    = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge FPGA_CLK) begin
    if (rst) begin
      state     <= IDLE;
      served    <= 4'h0;
      pending   <= 4'h0;
      hist      <= 4'hF;
      cnt       <= 8'd0;
      flash     <= 1'b0;
      walk      <= 4'h0;
      dont_walk <= 4'hF;
      walk_req  <= 1'b0;
      walk_done <= 1'b0;
      abort     <= 1'b0;
    end else begin
      state     <= state_n;
      served    <= served_n;
      pending   <= pending_n;
      hist      <= ped_btn;
      cnt       <= cnt_n;
      flash     <= flash_n;
      walk      <= walk_n;
      dont_walk <= dont_walk_n;
      walk_req  <= walk_req_n;
      walk_done <= walk_done_n;
      abort     <= abort_n;
    end
  end

endmodule

// File: tb/tb_ped_walk_scheduler.sv
// Bench for ped_walk_scheduler: directed scenarios plus random traffic, each cycle's
// expected outputs come from an elapsed-tick service model and are queued for a monitor.
module tb_ped_walk_scheduler;
  localparam int W  = 4;
  localparam int F  = 2;
  localparam int OW = 15;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [3:0] ped_btn = 4'h0;
  logic       fsm_safe = 1'b0;
  logic       walk_req, walk_done, abort;
  logic [3:0] walk, dont_walk, pending;
  logic [2:0] dbg_state;

  ped_walk_scheduler #(.WALK_TICKS(W), .FLASH_TICKS(F)) dut (
    .FPGA_CLK (clk),
    .rst      (rst),
    .tick     (tick),
    .ped_btn  (ped_btn),
    .fsm_safe (fsm_safe),
    .walk_req (walk_req),
    .walk     (walk),
    .dont_walk(dont_walk),
    .pending  (pending),
    .walk_done(walk_done),
    .abort    (abort),
    .dbg_state(dbg_state)
  );

  // Scoreboard
  logic [OW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: modes 0=idle 1=waiting-for-safe 2=serving 3=done-pulse.
  // Serving phase is derived from ticks elapsed since the service began.
  int         m_mode = 0;
  int         m_elapsed = 0;
  logic [3:0] m_pend = 4'h0;
  logic [3:0] m_served = 4'h0;
  logic [3:0] m_hist = 4'hF;
  logic       m_abort = 1'b0;

  function automatic logic [OW-1:0] model_out();
    logic [3:0] w, dw;
    logic req;
    req = (m_mode == 1) || (m_mode == 2);
    w   = 4'h0;
    dw  = 4'hF;
    if (m_mode == 2) begin
      if (m_elapsed < W) begin
        w  = m_served;
        dw = ~m_served;
      end else if (((m_elapsed - W) % 2) == 0) begin
        dw = 4'hF;
      end else begin
        dw = ~m_served;
      end
    end
    return {req, w, dw, m_pend, (m_mode == 3), m_abort};
  endfunction

  task automatic model_step(input logic [3:0] b, input logic t, input logic s, input logic r);
    logic [3:0] press, newp, old;
    m_abort = 1'b0;
    if (r) begin
      m_mode = 0; m_elapsed = 0; m_pend = 4'h0; m_served = 4'h0; m_hist = 4'hF;
      return;
    end
    press  = b & ~m_hist;
    m_hist = b;
    newp   = press & ~m_served;
    old    = m_pend;
    case (m_mode)
      0: begin
        m_pend = old | newp;
        if (old != 4'h0) m_mode = 1;
      end
      1: begin
        if (s) begin
          m_served  = old;
          m_pend    = (old | newp) & ~old;
          m_elapsed = 0;
          m_mode    = 2;
        end else begin
          m_pend = old | newp;
        end
      end
      2: begin
        m_pend = old | newp;
        if (!s) begin
          m_pend   = m_pend | m_served;
          m_served = 4'h0;
          m_mode   = 0;
          m_abort  = 1'b1;
        end else if (t) begin
          m_elapsed++;
          if (m_elapsed == W + F) begin
            m_mode   = 3;
            m_served = 4'h0;
          end
        end
      end
      default: begin
        m_pend = old | newp;
        m_mode = 0;
      end
    endcase
  endtask

  // Driver tasks
  int tick_div  = 0;
  bit rand_tick = 0;

  task automatic drive(input logic [3:0] b, input logic s, input logic r);
    logic t;
    @(negedge clk);
    if (rand_tick) begin
      t = ($urandom_range(0, 3) == 0);
    end else begin
      t = (tick_div == 9);
      tick_div = (tick_div + 1) % 10;
    end
    ped_btn  = b;
    fsm_safe = s;
    rst      = r;
    tick     = t;
    model_step(b, t, s, r);
    exp_q.push_back(model_out());
  endtask

  task automatic idle_n(input int n, input logic s);
    for (int i = 0; i < n; i++) drive(4'h0, s, 1'b0);
  endtask

  // Monitor: outputs are present every cycle, sampled 1 time unit after the edge
  initial begin
    logic [OW-1:0] e, a;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {walk_req, walk, dont_walk, pending, walk_done, abort};
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL outputs cyc %0d: got req=%b walk=%b dw=%b pend=%b done=%b abort=%b; exp req=%b walk=%b dw=%b pend=%b done=%b abort=%b",
                   cyc, a[14], a[13:10], a[9:6], a[5:2], a[1], a[0],
                   e[14], e[13:10], e[9:6], e[5:2], e[1], e[0]);
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [3:0] cur_btn;
    logic       cur_safe;
    bit         reached;

    // Reset with N held through it: the held button must not register
    for (int i = 0; i < 3; i++) drive(4'b0001, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) drive(4'b0001, 1'b0, 1'b0);
    idle_n(3, 1'b0);

    // Single request with safe already high
    drive(4'b0001, 1'b1, 1'b0);
    idle_n(80, 1'b1);

    // Delayed safe: E waits in request for 50 cycles
    drive(4'b0100, 1'b0, 1'b0);
    idle_n(50, 1'b0);
    idle_n(80, 1'b1);

    // Press during service: repeat N ignored, W latched for the next service
    drive(4'b0001, 1'b1, 1'b0);
    idle_n(12, 1'b1);
    drive(4'b1001, 1'b1, 1'b0);
    idle_n(160, 1'b1);

    // Abort during WALK for N+S, then recover
    drive(4'b0011, 1'b1, 1'b0);
    idle_n(15, 1'b1);
    idle_n(10, 1'b0);
    idle_n(90, 1'b1);

    // Reset during the flashing clearance
    drive(4'b0010, 1'b1, 1'b0);
    reached = 0;
    for (int k = 0; k < 300 && !reached; k++) begin
      if (m_mode == 2 && m_elapsed >= W) reached = 1;
      else drive(4'h0, 1'b1, 1'b0);
    end
    n_checks++;
    if (!reached) begin
      n_fail++;
      $display("FAIL clear_reach: clearance phase not reached within 300 cycles");
    end
    drive(4'h0, 1'b1, 1'b1);
    idle_n(5, 1'b1);

    // Random traffic
    cur_btn  = 4'h0;
    cur_safe = 1'b1;
    rand_tick = 1;
    for (int i = 0; i < 3000; i++) begin
      for (int j = 0; j < 4; j++)
        if ($urandom_range(0, 7) == 0) cur_btn[j] = ~cur_btn[j];
      if (cur_safe) begin
        if ($urandom_range(0, 199) == 0) cur_safe = 1'b0;
      end else if ($urandom_range(0, 14) == 0) begin
        cur_safe = 1'b1;
      end
      drive(cur_btn, cur_safe, ($urandom_range(0, 499) == 0));
    end
    rand_tick = 0;
    idle_n(3, 1'b1);

    // Drain: every queued expectation must have been consumed
    @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ped_walk_scheduler.md
# ped_walk_scheduler

Pedestrian-crossing scheduler that sits beside the intersection traffic FSM in `TOP`. It latches button presses from four crosswalks and requests an all-red hold from the traffic FSM through a req/safe handshake. Once the FSM reports all-red, it serves every pending crosswalk together: timed WALK, then flashing DON'T WALK, then it releases the hold. It runs on the board clock and uses the divider's tick strobe as its time base.

## Interface
Parameters:
- `WALK_TICKS`, 10: number of tick strobes in the steady WALK phase; legal range 1..255.
- `FLASH_TICKS`, 6: number of tick strobes in the flashing clearance phase; legal range 1..255.

Ports:
- `FPGA_CLK`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `tick`  in  1  one-cycle time-base strobe from the clock divider.
- `ped_btn`  in  4  crosswalk buttons, already synchronous and debounced: bit0=N, bit1=S, bit2=E, bit3=W.
- `fsm_safe`  in  1  traffic FSM is holding all-red for pedestrians.
- `walk_req`  out  1  request to the traffic FSM to enter or hold all-red.
- `walk`  out  4  steady WALK lamp per crosswalk.
- `dont_walk`  out  4  DON'T WALK lamp per crosswalk.
- `pending`  out  4  latched, not-yet-served requests.
- `walk_done`  out  1  one-cycle pulse when a service completes normally.
- `abort`  out  1  one-cycle pulse when `fsm_safe` drops mid-service.

## Operation
- Reset values: `walk`=0, `dont_walk`=4'hF, `walk_req`=0, `pending`=0, `walk_done`=0, `abort`=0, state IDLE, served set=0, button history=4'hF.
- Because history resets to all ones, a button held through reset is not counted until it is released and pressed again.
- Press detection: a rising edge of `ped_btn[i]` (current 1, previous-cycle 0) sets `pending[i]` on that edge.
- A press is ignored when `pending[i]` is already 1, or when crosswalk i is in the current served set during WALK or CLEAR.
- States:
  - IDLE: `walk_req`=0. If `pending`≠0, go to REQ.
  - REQ: `walk_req`=1. On an edge that samples `fsm_safe`=1: snapshot served set = `pending`, clear those pending bits, load counter = `WALK_TICKS`, go to WALK.
  - WALK: `walk[i]`=1 and `dont_walk[i]`=0 for served i. Every tick decrements the counter. A tick seen with counter==1 loads counter = `FLASH_TICKS`, sets flash phase = 1, and goes to CLEAR.
  - CLEAR: `walk`=0. `dont_walk[i]` = flash phase for served i. Each tick toggles the flash phase and decrements the counter. A tick seen with counter==1 goes to DONE.
  - DONE: for one cycle, `walk_done`=1, `walk_req`=0, all `dont_walk`=1, served set cleared; then go to IDLE.
- Crosswalks not in the served set keep `walk`=0 and `dont_walk`=1 in every state.
- Abort: `fsm_safe`=0 sampled in WALK or CLEAR causes, on that edge:
  - `walk`=0, `dont_walk`=4'hF, `walk_req`=0;
  - `abort` pulses for one cycle;
  - served bits are OR-ed back into `pending`;
  - served set cleared; state goes to IDLE.
- Presses arriving during service from crosswalks outside the served set are latched and served in the next REQ cycle. The block always passes through at least one IDLE cycle with `walk_req`=0 between services.
- `rst` asserted in any state returns all state and outputs to reset values on that edge. Pending requests are discarded.
- Counter is 8 bits and never wraps: it is reloaded on every entry to WALK or CLEAR.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Press to `pending`: the press is visible in `pending` one edge after it is sampled.
- Handshake with `fsm_safe` already high: button edge E0 sets `pending`; E1 enters REQ and raises `walk_req`; E2 enters WALK and raises `walk`.
- The traffic FSM must keep `fsm_safe` high until `walk_req` falls.
- A `tick` on the same edge as WALK or CLEAR entry is not counted. WALK lasts exactly `WALK_TICKS` ticks after entry; CLEAR lasts exactly `FLASH_TICKS` ticks after entry.
- `walk_req` stays high continuously from REQ through CLEAR and falls on the DONE edge.
- `walk_done` and `abort` are never high in the same cycle.

## Test plan
Common bench setup: `WALK_TICKS`=4, `FLASH_TICKS`=2, `tick` every 10 clocks.

- Reset: hold `ped_btn`=4'b0001 through `rst`, then release `rst`. Required: `pending` stays 0, `dont_walk`=4'hF, `walk_req`=0.
- Single request, `fsm_safe` tied 1: press N. Required:
  - `pending`=0001 after 1 edge; `walk_req`=1 after 2 edges; `walk`=0001 after 3 edges;
  - `walk` held for 4 ticks;
  - `dont_walk[0]` reads 1 then 0 across the 2 CLEAR ticks;
  - then `walk_done` pulses once and `walk_req`=0.
- Delayed safe: press E with `fsm_safe`=0 for 50 cycles, then raise it. Required: `walk_req` stays high with `walk`=0 throughout the wait; `walk`=0100 on the edge after `fsm_safe` rises.
- Press during service: while serving N (set 0001), press N again and press W. Required: N press ignored; `pending`=1000; W served in the next service after one IDLE cycle with `walk_req`=0.
- Abort: drop `fsm_safe` during WALK for set 0011. Required: same edge gives `walk`=0, `dont_walk`=4'hF, `abort`=1 for one cycle, `pending`=0011, `walk_done` stays 0.
- Mid-service reset: assert `rst` during CLEAR. Required: all outputs at reset values on the next edge and `pending`=0.
